// File: rtl/pipelined_signed_adder.sv
// Two-stage pipelined signed adder with per-operand defaults, valid/ready handshake,
// optional running accumulate and wrap-or-saturate overflow handling.
module pipelined_signed_adder #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned OUT_WIDTH = 6,
    parameter int          A_DEFAULT = 1,
    parameter int          B_DEFAULT = 2,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic        [WIDTH-1:0]     a,
    input  logic        [WIDTH-1:0]     b,
    input  logic                        a_en,
    input  logic                        b_en,
    input  logic                        acc_en,
    input  logic                        acc_clr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] result,
    output logic                        ovf
);

    localparam int unsigned EW = OUT_WIDTH + 1;

    localparam logic signed [EW-1:0]        A_EXT   = EW'(A_DEFAULT);
    localparam logic signed [EW-1:0]        B_EXT   = EW'(B_DEFAULT);
    localparam logic signed [OUT_WIDTH-1:0] RES_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] RES_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic                        s1_valid;
    logic signed [EW-1:0]        s1_ea;
    logic signed [EW-1:0]        s1_eb;
    logic                        s1_acc_en;
    logic                        s1_acc_clr;
    logic signed [OUT_WIDTH-1:0] acc;

    logic                        s1_load_c;
    logic                        s2_load_c;
    logic signed [EW-1:0]        ea_c;
    logic signed [EW-1:0]        eb_c;
    logic signed [EW-1:0]        acc_term_c;
    logic signed [EW-1:0]        raw_c;
    logic                        ovf_c;
    logic signed [OUT_WIDTH-1:0] final_c;

    // Handshake: S1 may refill in the same cycle it hands its contents to S2.
    assign s2_load_c = s1_valid && (!out_valid || out_ready);
    assign in_ready  = !s1_valid || s2_load_c;
    assign s1_load_c = in_valid && in_ready;

    // Effective operands, sign-extended one bit past the result width.
    always_comb begin
        ea_c = A_EXT;
        eb_c = B_EXT;
        if (a_en) ea_c = {{(EW-WIDTH){a[WIDTH-1]}}, a};
        if (b_en) eb_c = {{(EW-WIDTH){b[WIDTH-1]}}, b};
    end

    // Sum plus optional accumulator; the extra bit makes the range check exact.
    always_comb begin
        acc_term_c = '0;
        if (s1_acc_en && !s1_acc_clr) acc_term_c = {acc[OUT_WIDTH-1], acc};
        raw_c   = s1_ea + s1_eb + acc_term_c;
        ovf_c   = raw_c[EW-1] ^ raw_c[EW-2];
        final_c = raw_c[OUT_WIDTH-1:0];
        if (SATURATE && ovf_c) final_c = raw_c[EW-1] ? RES_MIN : RES_MAX;
    end

    // Stage 1: operand capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_ea      <= '0;
            s1_eb      <= '0;
            s1_acc_en  <= 1'b0;
            s1_acc_clr <= 1'b0;
        end else begin
            if (s1_load_c) begin
                s1_ea      <= ea_c;
                s1_eb      <= eb_c;
                s1_acc_en  <= acc_en;
                s1_acc_clr <= acc_clr;
            end
            if (s1_load_c)      s1_valid <= 1'b1;
            else if (s2_load_c) s1_valid <= 1'b0;
        end
    end

    // Stage 2: result register and accumulator, updated together on the S1->S2 move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            acc       <= '0;
        end else if (s2_load_c) begin
            out_valid <= 1'b1;
            result    <= final_c;
            ovf       <= ovf_c;
            if (s1_acc_en)       acc <= final_c;
            else if (s1_acc_clr) acc <= '0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
